mul_seq: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 12 +
 rtl/adder32.sv | 22 ++
 rtl/mul_seq.sv | 100 ++++++++++
 tb/tb_mul_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mul_seq_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-carry adder; the carry-out is dropped so the sum wraps mod 2^32.
module adder32
    import mul_seq_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [MUL_WIDTH-1:0] sum
);

    logic w_carry;

    always_comb begin
        w_carry = carry_in;
        sum     = '0;
        for (int i = 0; i < MUL_WIDTH; i++) begin
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Shift-and-add multiplier returning the low 32 bits of a*b, one add step per
// clock, finishing as soon as the remaining multiplier bits are all zero.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [MUL_WIDTH-1:0] result
);

    mul_state_t           r_state;
    mul_state_t           w_state_nxt;
    logic [MUL_WIDTH-1:0] r_acc;
    logic [MUL_WIDTH-1:0] r_mcand;
    logic [MUL_WIDTH-1:0] r_mplier;
    logic [MUL_WIDTH-1:0] w_sum;

    adder32 u_adder (
        .a        (r_acc),
        .b        (r_mcand),
        .carry_in (1'b0),
        .sum      (w_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (req_valid) w_state_nxt = RUN;
            // Last step is the one whose shifted-out remainder is empty.
            RUN:  if (r_mplier[MUL_WIDTH-1:1] == '0) w_state_nxt = DONE;
            DONE: if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                    end
                end
                RUN: begin
                    r_acc    <= r_mplier[0] ? w_sum : r_acc;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign result     = r_acc;

`ifdef FORMAL
    logic [MUL_WIDTH-1:0] r_fa;
    logic [MUL_WIDTH-1:0] r_fb;
    logic [5:0]           r_frun;

    always_ff @(posedge clk) begin
        if (r_state == IDLE && req_valid) begin
            r_fa   <= a;
            r_fb   <= b;
            r_frun <= '0;
        end else if (r_state == RUN) begin
            r_frun <= r_frun + 6'd1;
        end
    end

    always_comb begin
        assert (r_state == IDLE || r_state == RUN || r_state == DONE);
        if (r_state == DONE) assert (r_acc == r_fa * r_fb);
        if (r_state == RUN)  assert (r_frun < 6'd32);
    end
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomized checks of mul_seq against hand-computed products and latencies.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] av, input logic [31:0] bv, input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        a         = av;
        b         = bv;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        a         = 32'hDEAD_BEEF;
        b         = 32'hCAFE_F00D;
    endtask

    task automatic wait_done(input int exp_n, input logic [31:0] exp_r, input string tag,
                             input bit chk_rdy);
        int n = 0;
        while (!resp_valid && n < 40) begin
            if (chk_rdy) check({tag, "_run_ready"}, {31'd0, req_ready}, 32'd0);
            tick();
            n++;
        end
        check({tag, "_cycles"}, n, exp_n);
        check({tag, "_result"}, result, exp_r);
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    function automatic int calc_n(input logic [31:0] bv);
        int n = 1;
        for (int i = 0; i < 32; i++) if (bv[i]) n = i + 1;
        return n;
    endfunction

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        a          = '0;
        b          = '0;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_result",     result,              32'd0);

        // 7*6: three RUN cycles, ready low throughout
        accept(32'd7, 32'd6, "m7x6");
        wait_done(3, 32'd42, "m7x6", 1'b1);
        check("m7x6_done_ready", {31'd0, req_ready}, 32'd0);
        release_resp();
        check("m7x6_idle_ready", {31'd0, req_ready}, 32'd1);

        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap");
        wait_done(32, 32'h0000_0001, "wrap", 1'b0);
        release_resp();

        accept(32'h1234_5678, 32'h0, "bzero");
        wait_done(1, 32'h0, "bzero", 1'b0);
        release_resp();

        accept(32'h0, 32'h8000_0000, "msb");
        wait_done(32, 32'h0, "msb", 1'b0);
        release_resp();

        // back-pressure with a pending request held high
        accept(32'd3, 32'd5, "bp");
        wait_done(3, 32'd15, "bp", 1'b0);
        a         = 32'd2;
        b         = 32'd2;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid",  {31'd0, resp_valid}, 32'd1);
            check("bp_hold_result", result,              32'd15);
            check("bp_hold_ready",  {31'd0, req_ready},  32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_idle_ready", {31'd0, req_ready},  32'd1);
        check("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        wait_done(2, 32'd4, "pend2x2", 1'b0);
        release_resp();

        // reset in the third RUN cycle
        accept(32'd9, 32'hFF, "rstmid");
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rstmid_ready",  {31'd0, req_ready},  32'd1);
        check("rstmid_valid",  {31'd0, resp_valid}, 32'd0);
        check("rstmid_result", result,              32'd0);
        accept(32'd9, 32'hFF, "after_rst");
        wait_done(8, 32'h8F7, "after_rst", 1'b0);
        release_resp();

        for (int k = 0; k < 24; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [31:0] exp_r;
            int          hold;
            ra    = $urandom;
            rb    = $urandom >> $urandom_range(0, 31);
            exp_r = ra * rb;
            accept(ra, rb, "rnd");
            wait_done(calc_n(rb), exp_r, "rnd", 1'b0);
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("rnd_hold_result", result, exp_r);
            end
            release_resp();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
